// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: the mode enum, the default geometry, and the
// helper that turns a Fibonacci tap mask into a Galois XOR mask.
package lfsr_pkg;

  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_e;

  localparam int         LFSR_WIDTH = 8;
  localparam logic [7:0] LFSR_TAPS  = 8'hB8;
  localparam logic [7:0] LFSR_SEED  = 8'h01;

  // Galois mask is the tap mask moved up one place, with bit 0 forced on.
  // The caller truncates the result to its own width.
  function automatic logic [31:0] galois_mask(input logic [31:0] taps);
    return (taps << 1) | 32'd1;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR shift in either Fibonacci or Galois form.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH = LFSR_WIDTH
) (
  input  logic [WIDTH-1:0] s,
  input  lfsr_mode_e       mode,
  input  logic [WIDTH-1:0] taps,
  output logic [WIDTH-1:0] s_next
);

  logic [WIDTH-1:0] gal_mask;
  logic             fib_fb;

  assign gal_mask = WIDTH'(galois_mask(32'(taps)));
  assign fib_fb   = ^(s & taps);

  always_comb begin
    s_next = {s[WIDTH-2:0], fib_fb};
    if (mode == LFSR_GAL) begin
      s_next = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? gal_mask : '0);
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator: chained shifts per advance, seed load,
// all-zero lockup recovery and a period monitor.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_SEED),
  parameter int               STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             lockup,
  output logic             wrap,
  output logic [WIDTH-1:0] period
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             lockup_q, lockup_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] chain [STEPS+1];
  logic [WIDTH-1:0] adv;
  logic [WIDTH-1:0] cnt_inc;
  lfsr_mode_e       mode_e;

  assign mode_e   = lfsr_mode_e'(mode);
  assign chain[0] = q_q;

  for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
    lfsr_step #(.WIDTH(WIDTH)) u_step (
      .s      (chain[gi]),
      .mode   (mode_e),
      .taps   (TAPS),
      .s_next (chain[gi+1])
    );
  end

  assign adv = chain[STEPS];
  // The advance counter sticks at all-ones rather than rolling over.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    q_d      = q_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    lockup_d = 1'b0;
    wrap_d   = 1'b0;
    if (load) begin
      q_d     = seed_in;
      start_d = seed_in;
      cnt_d   = '0;
    end else if (en && (q_q == '0)) begin
      q_d      = SEED;
      start_d  = SEED;
      cnt_d    = '0;
      lockup_d = 1'b1;
    end else if (en) begin
      q_d = adv;
      if (adv == start_q) begin
        wrap_d   = 1'b1;
        period_d = cnt_inc;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q      <= SEED;
      start_q  <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      lockup_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      q_q      <= q_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      lockup_q <= lockup_d;
      wrap_q   <= wrap_d;
    end
  end

  assign q      = q_q;
  assign lockup = lockup_q;
  assign wrap   = wrap_q;
  assign period = period_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: single-step and eight-step instances,
// expected states queued at drive time and popped when the DUT updates.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst, en, load, mode, en8, load8;
  logic [7:0] seed_in;
  logic [7:0] q, period, q8, period8;
  logic       lockup, wrap, lockup8, wrap8;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(1)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in), .mode(mode),
    .q(q), .lockup(lockup), .wrap(wrap), .period(period)
  );

  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .STEPS(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .load(load8), .seed_in(seed_in), .mode(mode),
    .q(q8), .lockup(lockup8), .wrap(wrap8), .period(period8)
  );

  function automatic logic [7:0] m_fib(input logic [7:0] s);
    logic [7:0] t;
    logic       fb;
    t  = 8'hB8;
    fb = 1'b0;
    for (int i = 0; i < 8; i++) if (t[i]) fb = fb ^ s[i];
    return {s[6:0], fb};
  endfunction

  function automatic logic [7:0] m_gal(input logic [7:0] s);
    logic [7:0] t;
    logic [7:0] g;
    t = 8'hB8;
    g = {t[6:0], 1'b1};
    return s[7] ? ((s << 1) ^ g) : (s << 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; load = 1'b0; en8 = 1'b0; load8 = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; load = 1'b0; en8 = 1'b0; load8 = 1'b0;
    mode = 1'b0; seed_in = 8'h00;
    step(); step();
    total++; if (q !== 8'h01) begin bad++; $display("FAIL reset_q got=%h exp=01", q); end
    total++; if (period !== 8'h00) begin bad++; $display("FAIL reset_period got=%h exp=00", period); end
    total++; if ({lockup, wrap} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b exp=00", {lockup, wrap}); end
    total++; if (dut.cnt_q !== 8'h00) begin bad++; $display("FAIL reset_cnt got=%h exp=00", dut.cnt_q); end
    $display("reset: q=%h period=%h", q, period);
    en = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_fib_seq();
    logic [7:0] tbl [8] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};
    logic [7:0] e;
    do_reset();
    mode = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(tbl[i]);
      step();
      e = exp_q.pop_front();
      total++; if (q !== e) begin bad++; $display("FAIL fib_seq[%0d] got=%h exp=%h", i, q, e); end
      $display("fib advance %0d: q=%h", i + 1, q);
    end
    en = 1'b0;
  endtask

  task automatic test_gal_seq();
    logic [7:0] tbl [10] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h71, 8'hE2, 8'hB5};
    logic [7:0] e;
    logic [7:0] s;
    do_reset();
    mode = 1'b1; en = 1'b1;
    s = 8'h01;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(tbl[i]);
      s = m_gal(s);
      step();
      e = exp_q.pop_front();
      total++; if (q !== e) begin bad++; $display("FAIL gal_seq[%0d] got=%h exp=%h", i, q, e); end
      total++; if (q !== s) begin bad++; $display("FAIL gal_model[%0d] got=%h exp=%h", i, q, s); end
      $display("gal advance %0d: q=%h", i + 1, q);
    end
    en = 1'b0;
  endtask

  task automatic test_period();
    bit         seen [256];
    logic [7:0] s, e;
    do_reset();
    mode = 1'b0; en = 1'b1;
    s = 8'h01;
    seen[1] = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      s = m_fib(s);
      exp_q.push_back(s);
      step();
      e = exp_q.pop_front();
      total++; if (q !== e) begin bad++; $display("FAIL period_q[%0d] got=%h exp=%h", i, q, e); end
      total++; if (wrap !== (i == 255)) begin bad++; $display("FAIL period_wrap[%0d] got=%b exp=%b", i, wrap, (i == 255)); end
      if (i < 255) begin
        total++; if (seen[q]) begin bad++; $display("FAIL period_repeat[%0d] got=%h exp=new state", i, q); end
        seen[q] = 1'b1;
      end
    end
    total++; if (q !== 8'h01) begin bad++; $display("FAIL period_end_q got=%h exp=01", q); end
    $display("period run: advance 255 q=%h wrap=%b", q, wrap);
    en = 1'b0;
    step();
    total++; if (period !== 8'd255) begin bad++; $display("FAIL period_value got=%0d exp=255", period); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL period_wrap_clear got=%b exp=0", wrap); end
    $display("period hold: period=%0d", period);
  endtask

  task automatic test_lockup();
    logic [7:0] e;
    load = 1'b1; en = 1'b0; seed_in = 8'h00;
    exp_q.push_back(8'h00);
    step();
    e = exp_q.pop_front();
    total++; if (q !== e) begin bad++; $display("FAIL lockup_zero got=%h exp=%h", q, e); end
    total++; if (lockup !== 1'b0) begin bad++; $display("FAIL lockup_early got=%b exp=0", lockup); end
    $display("load zero: q=%h lockup=%b", q, lockup);
    load = 1'b0; en = 1'b1;
    exp_q.push_back(8'h01);
    step();
    e = exp_q.pop_front();
    total++; if (q !== e) begin bad++; $display("FAIL lockup_recover got=%h exp=%h", q, e); end
    total++; if (lockup !== 1'b1) begin bad++; $display("FAIL lockup_pulse got=%b exp=1", lockup); end
    $display("recover: q=%h lockup=%b", q, lockup);
    en = 1'b0;
    step();
    total++; if (lockup !== 1'b0) begin bad++; $display("FAIL lockup_clear got=%b exp=0", lockup); end
    total++; if (q !== 8'h01) begin bad++; $display("FAIL lockup_hold got=%h exp=01", q); end
    $display("after recover: q=%h lockup=%b", q, lockup);
  endtask

  task automatic test_load_priority();
    logic [7:0] e;
    mode = 1'b0; load = 1'b1; en = 1'b1; seed_in = 8'h5A;
    exp_q.push_back(8'h5A);
    step();
    e = exp_q.pop_front();
    total++; if (q !== e) begin bad++; $display("FAIL load_wins got=%h exp=%h", q, e); end
    $display("load+en: q=%h", q);
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (q !== 8'h5A) begin bad++; $display("FAIL load_hold[%0d] got=%h exp=5a", i, q); end
    end
    $display("hold: q=%h", q);
    en = 1'b1;
    exp_q.push_back(m_fib(8'h5A));
    step();
    e = exp_q.pop_front();
    total++; if (q !== e) begin bad++; $display("FAIL load_advance got=%h exp=%h", q, e); end
    $display("advance from 5a: q=%h", q);
    rst = 1'b0; load = 1'b1; en = 1'b1; seed_in = 8'h33;
    step();
    total++; if (q !== 8'h01) begin bad++; $display("FAIL midrst_q got=%h exp=01", q); end
    total++; if (period !== 8'h00) begin bad++; $display("FAIL midrst_period got=%h exp=00", period); end
    total++; if (dut.cnt_q !== 8'h00) begin bad++; $display("FAIL midrst_cnt got=%h exp=00", dut.cnt_q); end
    $display("mid-run reset: q=%h period=%h", q, period);
    rst = 1'b1; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_steps8();
    logic [7:0] s, e;
    do_reset();
    mode = 1'b0; en8 = 1'b1;
    s = 8'h01;
    for (int i = 1; i <= 255; i++) begin
      for (int k = 0; k < 8; k++) s = m_fib(s);
      exp_q.push_back(s);
      step();
      e = exp_q.pop_front();
      total++; if (q8 !== e) begin bad++; $display("FAIL steps8_q[%0d] got=%h exp=%h", i, q8, e); end
      total++; if (wrap8 !== (i == 255)) begin bad++; $display("FAIL steps8_wrap[%0d] got=%b exp=%b", i, wrap8, (i == 255)); end
      if (i == 1) begin
        total++; if (q8 !== 8'h1C) begin bad++; $display("FAIL steps8_first got=%h exp=1c", q8); end
        $display("steps8 first advance: q=%h", q8);
      end
    end
    total++; if (q8 !== 8'h01) begin bad++; $display("FAIL steps8_end got=%h exp=01", q8); end
    en8 = 1'b0;
    step();
    total++; if (period8 !== 8'd255) begin bad++; $display("FAIL steps8_period got=%0d exp=255", period8); end
    $display("steps8 period=%0d", period8);
  endtask

  initial begin
    test_reset();
    test_fib_seq();
    test_gal_seq();
    test_period();
    test_lockup();
    test_load_priority();
    test_steps8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
